// File: rtl/spectrum_bar_writer.sv
`default_nettype none
// ============================================================================
// spectrum_bar_writer : renders FFT magnitude bins as vertical bars into the
// SDRAM framebuffer through an Avalon-MM write master (one RGB565 pixel/beat).
// Revision: 1.0
// ============================================================================
module spectrum_bar_writer #(
    parameter int          H_RES     = 640,
    parameter int          V_RES     = 480,
    parameter int          NUM_BINS  = 64,
    parameter int          BAR_W     = 10,
    parameter int          MAG_W     = 16,
    parameter int          MAG_SHIFT = 4,
    parameter logic [31:0] FB_BASE   = 32'h0000_0000,
    parameter logic [15:0] BAR_COLOR = 16'h07E0,
    parameter logic [15:0] BG_COLOR  = 16'h0000
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic             bin_valid,
    output logic             bin_ready,
    input  logic [7:0]       bin_index,
    input  logic [MAG_W-1:0] bin_mag,
    output logic [31:0]      avm_address,
    output logic             avm_write,
    output logic [15:0]      avm_writedata,
    input  logic             avm_waitrequest,
    output logic             bin_done,
    output logic             frame_done,
    output logic             bin_err
);

    localparam int HT_W = $clog2(V_RES) + 1;
    localparam int Y_W  = $clog2(V_RES);
    localparam int X_W  = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [HT_W-1:0]  V_RES_H  = HT_W'(V_RES);
    localparam logic [X_W-1:0]   X_LAST   = X_W'(BAR_W - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(V_RES - 1);
    localparam logic [7:0]       LAST_BIN = 8'(NUM_BINS - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t state, next_state;

    logic [7:0]       idx;
    logic [HT_W-1:0]  height;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;

    logic             accept;
    logic             bad_bin;
    logic             xfer;
    logic             last_pixel;
    logic [X_W-1:0]   nx;
    logic [Y_W-1:0]   ny;
    logic [MAG_W-1:0] mag_shifted;
    logic [HT_W-1:0]  new_height;

    function automatic logic [31:0] pixel_addr(input logic [7:0]     i,
                                               input logic [X_W-1:0] px,
                                               input logic [Y_W-1:0] py);
        logic [31:0] off;
        off = 32'(py) * 32'(H_RES) + 32'(i) * 32'(BAR_W) + 32'(px);
        return FB_BASE + (off << 1);
    endfunction

    // Bar occupies the bottom 'h' rows of the strip.
    function automatic logic [15:0] pixel_color(input logic [Y_W-1:0]  py,
                                                input logic [HT_W-1:0] h);
        return (HT_W'(py) >= (V_RES_H - h)) ? BAR_COLOR : BG_COLOR;
    endfunction

    always_comb begin
        mag_shifted = bin_mag >> MAG_SHIFT;
        if (mag_shifted > MAG_W'(V_RES))
            new_height = V_RES_H;
        else
            new_height = HT_W'(mag_shifted);
    end

    assign last_pixel = (x == X_LAST) && (y == Y_LAST);
    assign nx         = (x == X_LAST) ? '0 : x + 1'b1;
    assign ny         = (x == X_LAST) ? y + 1'b1 : y;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        bad_bin    = 1'b0;
        xfer       = 1'b0;
        case (state)
            IDLE: begin
                if (bin_valid && bin_ready) begin
                    if (bin_index >= 8'(NUM_BINS)) begin
                        bad_bin = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        next_state = WRITE;
                    end
                end
            end
            WRITE: begin
                if (avm_write && !avm_waitrequest) begin
                    xfer = 1'b1;
                    if (last_pixel)
                        next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            bin_ready     <= 1'b0;
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
            bin_done      <= 1'b0;
            frame_done    <= 1'b0;
            bin_err       <= 1'b0;
            idx           <= '0;
            height        <= '0;
            x             <= '0;
            y             <= '0;
        end else begin
            bin_ready  <= (next_state == IDLE);
            bin_done   <= 1'b0;
            frame_done <= 1'b0;
            bin_err    <= bad_bin;
            if (accept) begin
                idx           <= bin_index;
                height        <= new_height;
                x             <= '0;
                y             <= '0;
                avm_write     <= 1'b1;
                avm_address   <= pixel_addr(bin_index, '0, '0);
                avm_writedata <= pixel_color('0, new_height);
            end else if (xfer) begin
                if (last_pixel) begin
                    avm_write  <= 1'b0;
                    bin_done   <= 1'b1;
                    frame_done <= (idx == LAST_BIN);
                end else begin
                    // Next pixel is presented immediately: no idle beat between transfers.
                    x             <= nx;
                    y             <= ny;
                    avm_address   <= pixel_addr(idx, nx, ny);
                    avm_writedata <= pixel_color(ny, height);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spectrum_bar_writer.sv
`default_nettype none
// Directed self-checking bench for spectrum_bar_writer (default parameters).
module tb_spectrum_bar_writer;

    localparam int NPIX    = 4800;
    localparam int BUDGET  = 20000;
    localparam logic [15:0] BAR = 16'h07E0;
    localparam logic [15:0] BG  = 16'h0000;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        bin_valid = 1'b0;
    logic        bin_ready;
    logic [7:0]  bin_index = 8'd0;
    logic [15:0] bin_mag = 16'd0;
    logic [31:0] avm_address;
    logic        avm_write;
    logic [15:0] avm_writedata;
    logic        avm_waitrequest = 1'b0;
    logic        bin_done;
    logic        frame_done;
    logic        bin_err;

    int tests = 0;
    int fails = 0;

    int nwr, bad_addr, bad_data, stall_chg, gaps, done_lat;
    bit done_seen, frame_seen, timeout;
    logic [31:0] wr_addr [0:NPIX-1];
    logic [15:0] wr_data [0:NPIX-1];

    spectrum_bar_writer dut (
        .clk_clk         (clk_clk),
        .reset_reset_n   (reset_reset_n),
        .bin_valid       (bin_valid),
        .bin_ready       (bin_ready),
        .bin_index       (bin_index),
        .bin_mag         (bin_mag),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .bin_done        (bin_done),
        .frame_done      (frame_done),
        .bin_err         (bin_err)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    function automatic logic [31:0] exp_addr(input int idx, input int k);
        return 32'(2 * ((k / 10) * 640 + idx * 10 + (k % 10)));
    endfunction

    function automatic logic [15:0] exp_data(input int k, input int h);
        return ((k / 10) >= (480 - h)) ? BAR : BG;
    endfunction

    function automatic int model_height(input int mag);
        int s;
        s = mag >> 4;
        return (s > 480) ? 480 : s;
    endfunction

    task automatic send_bin(input int idx, input int mag);
        bin_valid = 1'b1;
        bin_index = 8'(idx);
        bin_mag   = 16'(mag);
        step();
        bin_valid = 1'b0;
    endtask

    // Observes the write stream until bin_done (or stop_after completions).
    task automatic collect(input int idx, input int h, input bit rnd, input int stop_after);
        int          last_cyc   = -10;
        bit          prev_stall = 1'b0;
        bit          prev_cmp   = 1'b0;
        logic [31:0] pa         = '0;
        logic [15:0] pd         = '0;
        nwr = 0; bad_addr = 0; bad_data = 0; stall_chg = 0; gaps = 0;
        done_seen = 1'b0; frame_seen = 1'b0; done_lat = -1; timeout = 1'b1;
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            if (bin_done === 1'b1) begin
                done_seen  = 1'b1;
                frame_seen = frame_done;
                done_lat   = cyc - last_cyc;
                timeout    = 1'b0;
                break;
            end
            if (prev_stall && (avm_address !== pa || avm_writedata !== pd || avm_write !== 1'b1))
                stall_chg++;
            if (prev_cmp && avm_write !== 1'b1)
                gaps++;
            avm_waitrequest = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            prev_cmp = 1'b0;
            if (avm_write === 1'b1 && !avm_waitrequest) begin
                if (nwr < NPIX) begin
                    wr_addr[nwr] = avm_address;
                    wr_data[nwr] = avm_writedata;
                end
                if (avm_address !== exp_addr(idx, nwr)) bad_addr++;
                if (avm_writedata !== exp_data(nwr, h)) bad_data++;
                nwr++;
                last_cyc = cyc;
                prev_cmp = (nwr < NPIX);
            end
            prev_stall = (avm_write === 1'b1) && avm_waitrequest;
            pa = avm_address;
            pd = avm_writedata;
            step();
            if (stop_after > 0 && nwr == stop_after) begin
                timeout = 1'b0;
                break;
            end
        end
        avm_waitrequest = 1'b0;
    endtask

    initial begin
        int h;
        int cnt;

        // Reset state
        step();
        check("rst_ready", bin_ready, 0);
        check("rst_write", avm_write, 0);
        check("rst_addr", avm_address, 0);
        check("rst_data", avm_writedata, 0);
        check("rst_pulses", {bin_done, frame_done, bin_err}, 0);
        reset_reset_n = 1'b1;
        check("release_ready_low", bin_ready, 0);
        step();
        check("ready_after_rst", bin_ready, 1);

        // Bin 0, height 240
        h = model_height(16'h0F00);
        send_bin(0, 16'h0F00);
        check("b0_write_rise", avm_write, 1);
        check("b0_ready_busy", bin_ready, 0);
        collect(0, h, 1'b0, 0);
        check("b0_timeout", timeout, 0);
        check("b0_count", nwr, NPIX);
        check("b0_bad_addr", bad_addr, 0);
        check("b0_bad_data", bad_data, 0);
        check("b0_gaps", gaps, 0);
        check("b0_first_addr", wr_addr[0], 0);
        check("b0_first_data", wr_data[0], BG);
        check("b0_row239", wr_data[2390], BG);
        check("b0_row240", wr_data[2400], BAR);
        check("b0_last_addr", wr_addr[NPIX-1], 613138);
        check("b0_last_data", wr_data[NPIX-1], BAR);
        check("b0_done_lat", done_lat, 1);
        check("b0_frame", frame_seen, 0);
        check("b0_write_off", avm_write, 0);
        check("b0_ready_back", bin_ready, 1);
        step();
        check("b0_done_one_cycle", bin_done, 0);

        // Bin 3, clamped to full height; a bin offered while busy must be ignored
        h = model_height(16'hFFFF);
        send_bin(3, 16'hFFFF);
        bin_valid = 1'b1;
        bin_index = 8'd9;
        collect(3, h, 1'b0, 0);
        bin_valid = 1'b0;
        check("b3_count", nwr, NPIX);
        check("b3_bad_addr", bad_addr, 0);
        check("b3_bad_data", bad_data, 0);
        check("b3_addr0", wr_addr[0], 60);
        check("b3_addr1", wr_addr[1], 62);
        check("b3_addr10", wr_addr[10], 1340);
        check("b3_data0", wr_data[0], BAR);
        step();

        // Bin 5 with random stalls
        h = model_height(16'h1234);
        send_bin(5, 16'h1234);
        collect(5, h, 1'b1, 0);
        check("b5_timeout", timeout, 0);
        check("b5_count", nwr, NPIX);
        check("b5_bad_addr", bad_addr, 0);
        check("b5_bad_data", bad_data, 0);
        check("b5_stall_stable", stall_chg, 0);
        check("b5_gaps", gaps, 0);
        check("b5_done_lat", done_lat, 1);
        step();

        // Out-of-range bin
        send_bin(64, 16'h0100);
        check("err_pulse", bin_err, 1);
        check("err_no_write", avm_write, 0);
        check("err_ready", bin_ready, 1);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (avm_write !== 1'b0 || bin_err !== 1'b0) cnt++;
        end
        check("err_quiet", cnt, 0);

        // Last bin, zero magnitude
        send_bin(63, 0);
        collect(63, 0, 1'b0, 0);
        check("b63_count", nwr, NPIX);
        check("b63_bad_addr", bad_addr, 0);
        check("b63_bad_data", bad_data, 0);
        check("b63_done", done_seen, 1);
        check("b63_frame", frame_seen, 1);
        step();
        check("b63_frame_one_cycle", frame_done, 0);

        // Reset in the middle of bin 2
        h = model_height(16'h0800);
        send_bin(2, 16'h0800);
        collect(2, h, 1'b0, 100);
        check("b2_partial_count", nwr, 100);
        check("b2_partial_addr", bad_addr, 0);
        check("b2_still_writing", avm_write, 1);
        reset_reset_n = 1'b0;
        #1;
        check("async_write_drop", avm_write, 0);
        check("async_addr_clear", avm_address, 0);
        step();
        step();
        reset_reset_n = 1'b1;
        check("rel_ready_low", bin_ready, 0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bin_done !== 1'b0 || frame_done !== 1'b0 || avm_write !== 1'b0) cnt++;
        end
        check("rel_no_done", cnt, 0);
        check("rel_ready", bin_ready, 1);
        send_bin(2, 16'h0800);
        collect(2, h, 1'b0, 0);
        check("b2_count", nwr, NPIX);
        check("b2_addr0", wr_addr[0], 40);
        check("b2_bad_addr", bad_addr, 0);
        check("b2_bad_data", bad_data, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
